// File: rtl/icon_loader_if.sv
// icon_loader_if: pixel stream in and icon RAM write port out of icon_loader.
// The master side is the pixel source that also observes the RAM write bus.
interface icon_loader_if;
   logic [7:0] px_data;
   logic       px_valid;
   logic       px_ready;
   logic       ram_we;
   logic [7:0] ram_addr;
   logic [7:0] ram_wdata;

   modport master (
      output px_data, px_valid,
      input  px_ready, ram_we, ram_addr, ram_wdata
   );

   modport slave (
      input  px_data, px_valid,
      output px_ready, ram_we, ram_addr, ram_wdata
   );
endinterface

// File: rtl/icon_loader.sv
// icon_loader: writes the BLANK entry, then a raster-ordered icon, into the icon RAM.
// Define ICON_LOADER_CHKSUM_EN to add an XOR checksum of accepted pixels.
module icon_loader #(
   parameter int         ICON_WIDTH  = 15,
   parameter int         ICON_HEIGHT = 15,
   parameter logic [7:0] BLANK       = 8'd226,
   parameter logic [7:0] TRANSPARENT = 8'h00
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic abort,
   icon_loader_if.slave bus,
   output logic busy,
   output logic done
`ifdef ICON_LOADER_CHKSUM_EN
   ,
   output logic [7:0] chksum
`endif
);
   typedef enum logic [1:0] {IDLE, BLANKW, LOAD, DONE} state_t;

   localparam logic [7:0] COL_LAST = 8'(ICON_WIDTH - 1);
   localparam logic [7:0] ROW_LAST = 8'(ICON_HEIGHT - 1);

   state_t     state, state_nx;
   logic [7:0] row, col, lin;
   logic       accept, last;

   assign accept = (state == LOAD) && bus.px_valid;
   assign last   = (row == ROW_LAST) && (col == COL_LAST);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx     = state;
      bus.px_ready = 1'b0;
      busy         = 1'b1;
      done         = 1'b0;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nx = BLANKW;
         end
         BLANKW: state_nx = LOAD;
         LOAD: begin
            bus.px_ready = 1'b1;
            if (accept && last) state_nx = DONE;
         end
         DONE: begin
            done     = !abort;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      // abort overrides every transition, including start and a final accept
      if (abort) state_nx = IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.ram_we    <= 1'b0;
         bus.ram_addr  <= 8'd0;
         bus.ram_wdata <= 8'd0;
         row           <= 8'd0;
         col           <= 8'd0;
         lin           <= 8'd0;
      end else begin
         bus.ram_we <= 1'b0;
         if (!abort) begin
            if (state == BLANKW) begin
               bus.ram_we    <= 1'b1;
               bus.ram_addr  <= BLANK;
               bus.ram_wdata <= TRANSPARENT;
               row           <= 8'd0;
               col           <= 8'd0;
               lin           <= 8'd0;
            end else if (accept) begin
               bus.ram_we    <= 1'b1;
               bus.ram_addr  <= lin;
               bus.ram_wdata <= bus.px_data;
               lin           <= lin + 8'd1;
               if (col == COL_LAST) begin
                  col <= 8'd0;
                  row <= row + 8'd1;
               end else begin
                  col <= col + 8'd1;
               end
            end
         end
      end
   end

`ifdef ICON_LOADER_CHKSUM_EN
   always_ff @(posedge clk) begin
      if (reset)
         chksum <= 8'd0;
      else if (state == IDLE && start && !abort)
         chksum <= 8'd0;
      else if (accept && !abort)
         chksum <= chksum ^ bus.px_data;
   end
`endif
endmodule
